// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Control stage in front of a 4-bit ALU (opcodes 000 add, 001 sub, 010 mul,
//   111 div). Accepts a 13-bit instruction over valid/ready and reads operands
//   from a 4-entry register file. It drives the ALU inputs, captures the ALU
//   outputs, writes the result back and reports completion with status flags.
//   Each instruction walks IDLE -> OPERAND -> EXECUTE -> WRITEBACK, one cycle
//   per state.
//
//   Instruction fields: opcode[12:10] dst[9:8] srcA[7:6] srcB[5:4] imm[3:0]
//   Opcode 011 is LOADI (reg[dst] = imm, ALU bypassed). Opcodes 100/101/110
//   are illegal: they set errFlag and write nothing.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   instrValid/instrReady      instruction handshake (ready only in IDLE)
//   instr[12:0]                encoded instruction
//   aluA, aluB, aluOpcode      registered operands/opcode driven to the ALU
//   aluResult, aluRemainder    ALU outputs
//   aluZero, aluOverflow       ALU flags
//   done                       one-cycle pulse during WRITEBACK
//   zeroFlag, overflowFlag,
//   errFlag                    status of the last completed instruction
//   rdAddr, rdData             combinational debug read of the register file
//
// Configuration macro
//   ALU_SEQ_REM_WB_EN : when defined, a successful DIV also writes the
//                       remainder to reg[(dst+1) mod 4].

module alu_sequencer #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instrValid,
  output logic              instrReady,
  input  logic [12:0]       instr,
  output logic [DATA_W-1:0] aluA,
  output logic [DATA_W-1:0] aluB,
  output logic [2:0]        aluOpcode,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] aluRemainder,
  input  logic              aluZero,
  input  logic              aluOverflow,
  output logic              done,
  output logic              zeroFlag,
  output logic              overflowFlag,
  output logic              errFlag,
  input  logic [1:0]        rdAddr,
  output logic [DATA_W-1:0] rdData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPERAND,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_MUL   = 3'b010,
    OP_LOADI = 3'b011,
    OP_DIV   = 3'b111
  } op_t;

  state_t state;
  state_t next_state;

  logic [12:0]       instr_q;
  logic [DATA_W-1:0] regs [4];

  logic [DATA_W-1:0] cap_result;
  logic              cap_zero;
  logic              cap_ovf;

  logic [2:0]        op;
  logic [1:0]        dst;
  logic [1:0]        src_a;
  logic [1:0]        src_b;
  logic [DATA_W-1:0] imm;
  logic              op_is_alu;
  logic              op_is_loadi;
  logic              div_by_zero;

  // Instruction fields, from the copy latched at acceptance
  always_comb begin
    op    = instr_q[12:10];
    dst   = instr_q[9:8];
    src_a = instr_q[7:6];
    src_b = instr_q[5:4];
    imm   = DATA_W'(instr_q[3:0]);
    op_is_alu   = (op == OP_ADD) || (op == OP_SUB) ||
                  (op == OP_MUL) || (op == OP_DIV);
    op_is_loadi = (op == OP_LOADI);
    // aluB still holds reg[srcB] during WRITEBACK, so divide-by-zero is
    // detected here rather than trusting whatever the ALU reports.
    div_by_zero = (op == OP_DIV) && (aluB == '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:      if (instrValid) next_state = S_OPERAND;
      S_OPERAND:   next_state = S_EXECUTE;
      S_EXECUTE:   next_state = S_WRITEBACK;
      S_WRITEBACK: next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    instrReady = (state == S_IDLE);
    done       = (state == S_WRITEBACK);
  end

`ifdef ALU_SEQ_REM_WB_EN
  logic [DATA_W-1:0] cap_rem;
  logic [1:0]        rem_dst;
  assign rem_dst = dst + 2'd1;
`else
  logic rem_unused;
  assign rem_unused = ^aluRemainder;
`endif

  // Datapath: instruction latch, ALU operand registers, capture, writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q      <= '0;
      regs         <= '{default: '0};
      aluA         <= '0;
      aluB         <= '0;
      aluOpcode    <= '0;
      cap_result   <= '0;
      cap_zero     <= 1'b0;
      cap_ovf      <= 1'b0;
      zeroFlag     <= 1'b0;
      overflowFlag <= 1'b0;
      errFlag      <= 1'b0;
`ifdef ALU_SEQ_REM_WB_EN
      cap_rem      <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (instrValid) instr_q <= instr;
        end
        S_OPERAND: begin
          aluA <= regs[src_a];
          aluB <= regs[src_b];
          if (op_is_alu) aluOpcode <= op;
        end
        S_EXECUTE: begin
          cap_result <= aluResult;
          cap_zero   <= aluZero;
          cap_ovf    <= aluOverflow;
`ifdef ALU_SEQ_REM_WB_EN
          cap_rem    <= aluRemainder;
`endif
        end
        S_WRITEBACK: begin
          if (op_is_loadi) begin
            regs[dst]    <= imm;
            zeroFlag     <= (imm == '0);
            overflowFlag <= 1'b0;
            errFlag      <= 1'b0;
          end else if (!op_is_alu || div_by_zero) begin
            errFlag <= 1'b1;
          end else begin
            regs[dst]    <= cap_result;
            zeroFlag     <= cap_zero;
            overflowFlag <= cap_ovf;
            errFlag      <= 1'b0;
`ifdef ALU_SEQ_REM_WB_EN
            if (op == OP_DIV) regs[rem_dst] <= cap_rem;
`endif
          end
        end
      endcase
    end
  end

  assign rdData = regs[rdAddr];

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instrValid;
  logic        instrReady;
  logic [12:0] instr;
  logic [3:0]  aluA, aluB;
  logic [2:0]  aluOpcode;
  logic [3:0]  aluResult, aluRemainder;
  logic        aluZero, aluOverflow;
  logic        done, zeroFlag, overflowFlag, errFlag;
  logic [1:0]  rdAddr;
  logic [3:0]  rdData;

  alu_sequencer #(.DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instrValid(instrValid), .instrReady(instrReady), .instr(instr),
    .aluA(aluA), .aluB(aluB), .aluOpcode(aluOpcode),
    .aluResult(aluResult), .aluRemainder(aluRemainder),
    .aluZero(aluZero), .aluOverflow(aluOverflow),
    .done(done), .zeroFlag(zeroFlag), .overflowFlag(overflowFlag),
    .errFlag(errFlag), .rdAddr(rdAddr), .rdData(rdData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment ALU. Divide-by-zero returns junk with overflow set, so a
  // sequencer that trusts the ALU there shows up as a mismatch.
  logic [4:0] sum5, dif5;
  logic [7:0] prod8;
  assign sum5  = {1'b0, aluA} + {1'b0, aluB};
  assign dif5  = {1'b0, aluA} - {1'b0, aluB};
  assign prod8 = {4'b0, aluA} * {4'b0, aluB};
  always_comb begin
    aluResult    = 4'h0;
    aluRemainder = 4'h0;
    aluOverflow  = 1'b0;
    case (aluOpcode)
      3'b000: begin aluResult = sum5[3:0];  aluOverflow = sum5[4]; end
      3'b001: begin aluResult = dif5[3:0];  aluOverflow = dif5[4]; end
      3'b010: begin aluResult = prod8[3:0]; aluOverflow = |prod8[7:4]; end
      3'b111: begin
        if (aluB == 4'h0) begin
          aluResult = 4'hF; aluRemainder = 4'hF; aluOverflow = 1'b1;
        end else begin
          aluResult = aluA / aluB; aluRemainder = aluA % aluB;
        end
      end
      default: aluResult = 4'hA;
    endcase
    aluZero = (aluResult == 4'h0);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] mk(input int op, input int d, input int sa,
                                     input int sb, input int im);
    return {3'(op), 2'(d), 2'(sa), 2'(sb), 4'(im)};
  endfunction

  // ---------------- behavioural model ----------------
  int          m_regs [4];
  int          m_zero, m_ovf, m_err;
  int          m_alu_a, m_alu_b, m_aluop;
  bit          pending;
  int          acc_cyc;
  logic [12:0] p_instr;
  int          cyc = 0;
  int          acc_count = 0;
  int          done_seen = 0;

  function automatic bit is_alu_op(input int op);
    return (op == 0) || (op == 1) || (op == 2) || (op == 7);
  endfunction

  // Apply the architectural effect of the pending instruction
  task automatic complete_instr();
    int op, d, a, b, im, res, rem, ovf;
    op  = int'(p_instr[12:10]);
    d   = int'(p_instr[9:8]);
    a   = m_regs[p_instr[7:6]];
    b   = m_regs[p_instr[5:4]];
    im  = int'(p_instr[3:0]);
    rem = 0;
    ovf = 0;
    res = 0;
    if (op == 3) begin
      m_regs[d] = im; m_zero = (im == 0); m_ovf = 0; m_err = 0;
    end else if (!is_alu_op(op) || (op == 7 && b == 0)) begin
      m_err = 1;
    end else begin
      case (op)
        0: begin res = (a + b) % 16; ovf = (a + b > 15); end
        1: begin res = (a - b + 16) % 16; ovf = (a < b); end
        2: begin res = (a * b) % 16; ovf = (a * b > 15); end
        default: begin res = a / b; rem = a % b; end
      endcase
      m_regs[d] = res; m_zero = (res == 0); m_ovf = ovf; m_err = 0;
`ifdef ALU_SEQ_REM_WB_EN
      if (op == 7) m_regs[(d + 1) % 4] = rem;
`endif
    end
  endtask

  // Model update on each rising edge, full comparison on each falling edge
  initial begin : model_and_compare
    bit was_pending;
    int op;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_zero = 0; m_ovf = 0; m_err = 0;
        m_alu_a = 0; m_alu_b = 0; m_aluop = 0;
        pending = 0;
      end else begin
        was_pending = pending;
        if (was_pending) begin
          if (cyc == acc_cyc + 1) begin
            op = int'(p_instr[12:10]);
            m_alu_a = m_regs[p_instr[7:6]];
            m_alu_b = m_regs[p_instr[5:4]];
            if (is_alu_op(op)) m_aluop = op;
          end
          if (cyc == acc_cyc + 3) begin
            complete_instr();
            pending = 0;
          end
        end else if (instrValid) begin
          pending = 1;
          acc_cyc = cyc;
          p_instr = instr;
          acc_count++;
        end
      end
      @(negedge clk);
      rdAddr = 2'(cyc % 4);
      #1;
      if (done) done_seen++;
      chk("instrReady", int'(instrReady), int'(!pending));
      chk("done", int'(done), int'(pending && cyc == acc_cyc + 2));
      chk("zeroFlag", int'(zeroFlag), m_zero);
      chk("overflowFlag", int'(overflowFlag), m_ovf);
      chk("errFlag", int'(errFlag), m_err);
      chk("aluA", int'(aluA), m_alu_a);
      chk("aluB", int'(aluB), m_alu_b);
      chk("aluOpcode", int'(aluOpcode), m_aluop);
      chk("rdData", int'(rdData), m_regs[cyc % 4]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [12:0] ins, input int hold_extra);
    int start;
    start = acc_count;
    @(negedge clk);
    #2;
    instr = ins;
    instrValid = 1'b1;
    for (int k = 0; k < 20 && acc_count == start; k++) @(negedge clk);
    chk("accept_count", acc_count - start, 1);
    repeat (hold_extra) @(negedge clk);
    #2;
    instrValid = 1'b0;
    instr = 13'($urandom);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && pending; k++) @(negedge clk);
    chk("idle_timeout", int'(pending), 0);
  endtask

  initial begin : stim
    int saved [4];
    int d0, a0, n_done;
    rst_n = 1'b0;
    instrValid = 1'b0;
    instr = '0;
    #1;
    chk("reset_ready", int'(instrReady), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_rd", int'(rdData), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // LOADI r0=9, LOADI r1=6, ADD r2=r0+r1
    send(mk(3, 0, 0, 0, 9), 0);
    send(mk(3, 1, 0, 0, 6), 0);
    send(mk(0, 2, 0, 1, 0), 0);
    wait_idle();
    chk("lit_add_r2", m_regs[2], 15);
    chk("lit_add_zero", m_zero, 0);
    chk("lit_add_err", m_err, 0);

    // MUL r3=r0*r1, then SUB r2=r0-r0
    send(mk(2, 3, 0, 1, 0), 0);
    wait_idle();
    chk("lit_mul_r3", m_regs[3], 6);
    chk("lit_mul_ovf", m_ovf, 1);
    send(mk(1, 2, 0, 0, 0), 0);
    wait_idle();
    chk("lit_sub_r2", m_regs[2], 0);
    chk("lit_sub_zero", m_zero, 1);

    // DIV r2=r0/r1
    send(mk(7, 2, 0, 1, 0), 0);
    wait_idle();
    chk("lit_div_r2", m_regs[2], 1);
`ifdef ALU_SEQ_REM_WB_EN
    chk("lit_div_r3", m_regs[3], 3);
    send(mk(7, 3, 0, 1, 0), 0);
    wait_idle();
    chk("lit_div_wrap_r3", m_regs[3], 1);
    chk("lit_div_wrap_r0", m_regs[0], 3);
    send(mk(3, 0, 0, 0, 9), 0);
`else
    chk("lit_div_r3", m_regs[3], 6);
`endif

    // Divide by zero
    send(mk(3, 1, 0, 0, 0), 0);
    wait_idle();
    d0 = m_regs[2];
    n_done = done_seen;
    send(mk(7, 2, 0, 1, 0), 0);
    wait_idle();
    chk("lit_dz_err", m_err, 1);
    chk("lit_dz_r2", m_regs[2], d0);
    chk("dz_done_pulses", done_seen - n_done, 1);

    // Illegal opcode with valid held through the busy cycles
    for (int i = 0; i < 4; i++) saved[i] = m_regs[i];
    n_done = done_seen;
    a0 = acc_count;
    send(mk(5, 1, 2, 3, 7), 3);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("ill_accepts", acc_count - a0, 1);
    chk("ill_done_pulses", done_seen - n_done, 1);
    chk("lit_ill_err", m_err, 1);
    for (int i = 0; i < 4; i++) chk("ill_regs", m_regs[i], saved[i]);

    // Reset during EXECUTE of ADD r2
    n_done = done_seen;
    send(mk(0, 2, 0, 0, 0), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(instrReady), 1);
    chk("rst_err", int'(errFlag), 0);
    chk("rst_aluA", int'(aluA), 0);
    chk("rst_rd", int'(rdData), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_seen - n_done, 0);
    for (int i = 0; i < 4; i++) chk("lit_rst_regs", m_regs[i], 0);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(13'($urandom), ($urandom_range(0, 3) == 0) ? 3 : 0);
    end
    wait_idle();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
